// File: rtl/oled_frame_arbiter.sv
// ============================================================================
// oled_frame_arbiter
//   Shares the single Oled_Display pixel_data input between up to NUM_CLIENTS
//   pixel producers. Panel ownership changes only on frame_begin, so a frame
//   is always drawn entirely by one client (or by the background colour).
//   Runs on the 6.25 MHz display clock.
//
// Parameters
//   NUM_CLIENTS  number of requesters (2..8)
//   HOLD_FRAMES  minimum frames a grant is kept once given (1..255)
//   BG_COLOUR    RGB565 pixel driven when no client is granted
//
// Ports
//   CLK           display clock, all logic on posedge
//   reset         synchronous, active-high
//   frame_begin   1-cycle pulse at start of each frame
//   pixel_index   current pixel index from Oled_Display (0..6143)
//   req           level request per client
//   prio_mode     0 = round-robin, 1 = fixed priority (lowest index wins)
//   client_pixel  RGB565 per client, client i at [16i+15:16i]
//   x, y          registered column/row of pixel_index (96 x 64 panel)
//   pixel_data    registered pixel to Oled_Display
//   grant         one-hot current owner, all-zero when idle
//   grant_valid   1 when grant is non-zero
//   frame_count   frames seen since reset, wraps 255 -> 0
// ============================================================================
module oled_frame_arbiter #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned HOLD_FRAMES = 1,
    parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        frame_begin,
    input  logic [12:0]                 pixel_index,
    input  logic [NUM_CLIENTS-1:0]      req,
    input  logic                        prio_mode,
    input  logic [16*NUM_CLIENTS-1:0]   client_pixel,
    output logic [6:0]                  x,
    output logic [5:0]                  y,
    output logic [15:0]                 pixel_data,
    output logic [NUM_CLIENTS-1:0]      grant,
    output logic                        grant_valid,
    output logic [7:0]                  frame_count
);

    localparam int unsigned IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned X_W    = 7;
    localparam int unsigned Y_W    = 6;
    localparam int unsigned IDX13  = 13;

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [IDX_W-1:0]  RR_RESET    = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [IDX13-1:0]  NUM_PIXELS  = 13'd6144;
    localparam logic [IDX13-1:0]  NUM_COLS    = 13'd96;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [NUM_CLIENTS-1:0]   grant_d;
    logic [HOLD_W-1:0]        hold_q;
    logic [HOLD_W-1:0]        hold_d;
    logic [IDX_W-1:0]         rr_q;
    logic [IDX_W-1:0]         rr_d;
    logic [NUM_CLIENTS-1:0]   win;
    logic                     take_win;
    logic [IDX_W-1:0]         grant_idx;

    // Winner among r: lowest set index, or first set index after ptr (wrapping).
    // Loops run from the far end so the preferred candidate is written last.
    function automatic logic [NUM_CLIENTS-1:0] pick_winner(
        input logic [NUM_CLIENTS-1:0] r,
        input logic                   fixed_prio,
        input logic [IDX_W-1:0]       ptr
    );
        logic [NUM_CLIENTS-1:0] w;
        int                     j;
        w = '0;
        j = 0;
        if (fixed_prio) begin
            for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
                if (r[i]) begin
                    w    = '0;
                    w[i] = 1'b1;
                end
            end
        end else begin
            for (int k = int'(NUM_CLIENTS); k >= 1; k--) begin
                j = (int'(ptr) + k) % int'(NUM_CLIENTS);
                if (r[j]) begin
                    w    = '0;
                    w[j] = 1'b1;
                end
            end
        end
        return w;
    endfunction

    // Index of the set bit of a one-hot (or zero) vector.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_CLIENTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Arbitration state register; grant and flags change only on frame_begin.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            hold_q      <= '0;
            rr_q        <= RR_RESET;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            grant_valid <= |grant_d;
            hold_q      <= hold_d;
            rr_q        <= rr_d;
        end
    end

    // Next-state logic, evaluated only at frame boundaries.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        hold_d   = hold_q;
        rr_d     = rr_q;
        take_win = 1'b0;
        win      = pick_winner(req, prio_mode, rr_q);

        if (frame_begin) begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        take_win = 1'b1;
                    end
                end
                GRANT: begin
                    if ((req & grant) == '0) begin
                        // Owner left: hand over or fall back to background.
                        if (|req) begin
                            take_win = 1'b1;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                            hold_d  = '0;
                        end
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if ((req & ~grant) != '0) begin
                        take_win = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end
            endcase
        end

        if (take_win) begin
            state_d = GRANT;
            grant_d = win;
            hold_d  = HOLD_RELOAD;
            rr_d    = onehot_to_idx(win);
        end
    end

    // Frame counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_begin) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    // Pixel coordinates; out-of-range indices map to the origin.
    always_ff @(posedge CLK) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (pixel_index >= NUM_PIXELS) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= X_W'(pixel_index % NUM_COLS);
            y <= Y_W'(pixel_index / NUM_COLS);
        end
    end

    assign grant_idx = onehot_to_idx(grant);

    // Pixel mux driven by the registered grant, so the source switches one
    // cycle after the grant becomes visible.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pixel_data <= BG_COLOUR;
        end else if (grant_valid) begin
            pixel_data <= client_pixel[int'(grant_idx) * int'(PIX_W) +: PIX_W];
        end else begin
            pixel_data <= BG_COLOUR;
        end
    end

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Directed bench for oled_frame_arbiter: one DUT with HOLD_FRAMES=1 and one
// with HOLD_FRAMES=3 share the same stimulus.
module tb_oled_frame_arbiter;

    logic        CLK;
    logic        reset;
    logic        frame_begin;
    logic [12:0] pixel_index;
    logic [3:0]  req;
    logic        prio_mode;
    logic [63:0] client_pixel;

    logic [6:0]  x1, x3;
    logic [5:0]  y1, y3;
    logic [15:0] pd1, pd3;
    logic [3:0]  g1, g3;
    logic        gv1, gv3;
    logic [7:0]  fc1, fc3;

    int tests;
    int failed;

    localparam logic [15:0] C0 = 16'hF800;
    localparam logic [15:0] C1 = 16'h07E0;
    localparam logic [15:0] C2 = 16'h001F;
    localparam logic [15:0] C3 = 16'hFFFF;

    oled_frame_arbiter #(.NUM_CLIENTS(4), .HOLD_FRAMES(1), .BG_COLOUR(16'h0000)) dut1 (
        .CLK(CLK), .reset(reset), .frame_begin(frame_begin), .pixel_index(pixel_index),
        .req(req), .prio_mode(prio_mode), .client_pixel(client_pixel),
        .x(x1), .y(y1), .pixel_data(pd1), .grant(g1), .grant_valid(gv1), .frame_count(fc1)
    );

    oled_frame_arbiter #(.NUM_CLIENTS(4), .HOLD_FRAMES(3), .BG_COLOUR(16'h0000)) dut3 (
        .CLK(CLK), .reset(reset), .frame_begin(frame_begin), .pixel_index(pixel_index),
        .req(req), .prio_mode(prio_mode), .client_pixel(client_pixel),
        .x(x3), .y(y3), .pixel_data(pd3), .grant(g3), .grant_valid(gv3), .frame_count(fc3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic frame_pulse();
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req          = 4'b0001;
        client_pixel = {C3, C2, C1, C0};
        reset        = 1'b1;
        tick();
        tests++;
        if (g1 !== 4'b0000) begin failed++; $display("FAIL reset_grant: got %b exp 0000", g1); end
        tests++;
        if (pd1 !== 16'h0000) begin failed++; $display("FAIL reset_pixel: got %h exp 0000", pd1); end
        // frame_begin coincident with reset must be ignored
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
        tests++;
        if (fc1 !== 8'd0) begin failed++; $display("FAIL reset_fc: got %0d exp 0", fc1); end
        tests++;
        if (g1 !== 4'b0000 || gv1 !== 1'b0) begin failed++; $display("FAIL reset_wins_fb: grant %b gv %b exp 0000/0", g1, gv1); end
        tests++;
        if (x1 !== 7'd0 || y1 !== 6'd0) begin failed++; $display("FAIL reset_xy: got %0d,%0d exp 0,0", x1, y1); end
        reset = 1'b0;
        tick();
        tests++;
        if (g1 !== 4'b0000) begin failed++; $display("FAIL wait_first_fb: got %b exp 0000", g1); end
        frame_pulse();
        tests++;
        if (g1 !== 4'b0001 || gv1 !== 1'b1) begin failed++; $display("FAIL first_grant: grant %b gv %b exp 0001/1", g1, gv1); end
        tests++;
        if (fc1 !== 8'd1) begin failed++; $display("FAIL first_fc: got %0d exp 1", fc1); end
    endtask

    task automatic test_midframe_req();
        req       = 4'b0000;
        prio_mode = 1'b0;
        do_reset();
        tick();
        req = 4'b0001;
        tick();
        tick();
        tests++;
        if (g1 !== 4'b0000 || pd1 !== 16'h0000) begin failed++; $display("FAIL midframe_ignored: grant %b pix %h exp 0000/0000", g1, pd1); end
        frame_pulse();
        tests++;
        if (g1 !== 4'b0001) begin failed++; $display("FAIL midframe_grant: got %b exp 0001", g1); end
        tests++;
        if (pd1 !== 16'h0000) begin failed++; $display("FAIL pixel_latency: got %h exp 0000", pd1); end
        tick();
        tests++;
        if (pd1 !== C0) begin failed++; $display("FAIL pixel_switch: got %h exp %h", pd1, C0); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g [5];
        logic [15:0] exp_p [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_p = '{C0, C1, C2, C3, C0};
        req       = 4'b1111;
        prio_mode = 1'b0;
        do_reset();
        tick();
        for (int f = 0; f < 5; f++) begin
            frame_pulse();
            tests++;
            if (g1 !== exp_g[f]) begin failed++; $display("FAIL rr_grant[%0d]: got %b exp %b", f, g1, exp_g[f]); end
            tick();
            tests++;
            if (pd1 !== exp_p[f]) begin failed++; $display("FAIL rr_pixel[%0d]: got %h exp %h", f, pd1, exp_p[f]); end
        end
    endtask

    task automatic test_fixed_priority();
        req       = 4'b1010;
        prio_mode = 1'b1;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            frame_pulse();
            tests++;
            if (g1 !== 4'b0010) begin failed++; $display("FAIL fixed_grant[%0d]: got %b exp 0010", f, g1); end
            tick();
        end
        req = 4'b1000;
        tick();
        tests++;
        if (g1 !== 4'b0010) begin failed++; $display("FAIL fixed_drop_midframe: got %b exp 0010", g1); end
        frame_pulse();
        tests++;
        if (g1 !== 4'b1000) begin failed++; $display("FAIL fixed_handover: got %b exp 1000", g1); end
    endtask

    task automatic test_hold_frames();
        logic [3:0] exp_g [6];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
        req       = 4'b0011;
        prio_mode = 1'b0;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            frame_pulse();
            tests++;
            if (g3 !== exp_g[f]) begin failed++; $display("FAIL hold_grant[%0d]: got %b exp %b", f, g3, exp_g[f]); end
            tick();
        end
    endtask

    task automatic test_release_and_coords();
        req       = 4'b0001;
        prio_mode = 1'b0;
        do_reset();
        frame_pulse();
        tick();
        req = 4'b0000;
        tick();
        tests++;
        if (g1 !== 4'b0001 || gv1 !== 1'b1) begin failed++; $display("FAIL release_hold: grant %b gv %b exp 0001/1", g1, gv1); end
        tests++;
        if (pd1 !== C0) begin failed++; $display("FAIL release_pixel_kept: got %h exp %h", pd1, C0); end
        frame_pulse();
        tests++;
        if (g1 !== 4'b0000 || gv1 !== 1'b0) begin failed++; $display("FAIL release_idle: grant %b gv %b exp 0000/0", g1, gv1); end
        tick();
        tests++;
        if (pd1 !== 16'h0000) begin failed++; $display("FAIL release_bg: got %h exp 0000", pd1); end
        pixel_index = 13'd6143;
        tick();
        tests++;
        if (x1 !== 7'd95 || y1 !== 6'd63) begin failed++; $display("FAIL coord_last: got %0d,%0d exp 95,63", x1, y1); end
        pixel_index = 13'd100;
        tick();
        tests++;
        if (x1 !== 7'd4 || y1 !== 6'd1) begin failed++; $display("FAIL coord_100: got %0d,%0d exp 4,1", x1, y1); end
        pixel_index = 13'd6144;
        tick();
        tests++;
        if (x1 !== 7'd0 || y1 !== 6'd0) begin failed++; $display("FAIL coord_oob: got %0d,%0d exp 0,0", x1, y1); end
        pixel_index = 13'd0;
    endtask

    task automatic test_frame_count_wrap();
        req = 4'b0000;
        do_reset();
        for (int f = 0; f < 255; f++) begin
            frame_pulse();
        end
        tests++;
        if (fc1 !== 8'd255) begin failed++; $display("FAIL fc_255: got %0d exp 255", fc1); end
        frame_pulse();
        tests++;
        if (fc1 !== 8'd0) begin failed++; $display("FAIL fc_wrap: got %0d exp 0", fc1); end
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        reset        = 1'b1;
        frame_begin  = 1'b0;
        pixel_index  = 13'd0;
        req          = 4'b0000;
        prio_mode    = 1'b0;
        client_pixel = {C3, C2, C1, C0};

        test_reset();
        test_midframe_req();
        test_round_robin();
        test_fixed_priority();
        test_hold_frames();
        test_release_and_coords();
        test_frame_count_wrap();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
